prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 2_700_000, SHALL be the maximum idle clock count between received bytes during a load.
REQ-002 Parameter HDR_BYTE, default 8'h4C, SHALL be the frame header byte.
REQ-003 clk  in  1  the one clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 load_req  in  1  one-cycle pulse that requests a program load.
REQ-006 rx_data  in  8  received UART byte.
REQ-007 rx_valid  in  1  one-cycle strobe that qualifies rx_data.
REQ-008 cpu_addr / cpu_wr / cpu_byt / cpu_wr_data  in  ADDR_WIDTH/1/1/16  CPU memory request.
REQ-009 mem_addr / mem_wr / mem_byt / mem_wr_data  out  ADDR_WIDTH/1/1/16  muxed memory port.
REQ-010 cpu_rst  out  1  holds the CPU in reset while high.
REQ-011 busy  out  1  high in every state except RUN.
REQ-012 err  out  1  sticky flag for a failed load; cleared by the next load_req.

Function
REQ-013 The FSM SHALL have these states: RUN, WAIT_HDR, LEN_H, LEN_L, DATA_L, DATA_H, CSUM, ERR.
REQ-014 RUN: load_req -> WAIT_HDR, cpu_rst=1 from the next cycle; load_req in any other state SHALL be ignored.
REQ-015 WAIT_HDR: rx_valid with HDR_BYTE -> LEN_H; any other byte SHALL be discarded; no timeout applies in this state.
REQ-016 LEN_H/LEN_L: capture the word count N (11 bits); N==0 or N>11'h680 at the LEN_L byte -> ERR.
REQ-017 DATA_L: latch the low byte -> DATA_H; DATA_H: on the byte, issue one write.
   - mem_wr=1 for exactly one cycle, the cycle after rx_valid.
   - mem_byt=0; mem_wr_data={hi,lo}.
   - mem_addr=12'h300+2*i for word i.
   - Then go to DATA_L, or to CSUM after word N-1.
REQ-018 Checksum: 8-bit wrap-around sum of all data bytes (headers and length excluded); in CSUM a matching byte -> RUN, a mismatch -> ERR.
REQ-019 Timeout: in LEN_H..CSUM, TIMEOUT_CYCLES cycles without rx_valid -> ERR; the counter SHALL restart on every rx_valid.
REQ-020 ERR: err=1, cpu_rst stays 1; a header byte -> LEN_H (err cleared); load_req -> WAIT_HDR (err cleared).
REQ-021 Port mux: in RUN, mem_* SHALL equal cpu_* combinationally; in every other state the loader drives mem_*, and when no write is pending mem_wr=0 and mem_addr=12'h300.
REQ-022 cpu_rst SHALL fall on the cycle after the FSM enters RUN, so the CPU restarts from ip=0300h.
REQ-023 rx_valid coincident with a timeout expiry: the byte SHALL win and the counter restarts.
REQ-024 A byte received while a write is still pending SHALL be accepted; the write is registered and never dropped.

Reset
REQ-025 rst SHALL force: state=RUN, cpu_rst=1 (released one cycle after rst falls), err=0, mem_wr driven by the RUN passthrough, checksum=0, word index=0, timeout counter=0.
REQ-026 rst mid-load SHALL abandon the load with no further loader writes; already-written words remain in memory.

Structure
REQ-027 The shared package SHALL hold the state enum, PROG_BASE=12'h300, PROG_MAX_WORDS=11'h680 and HDR_BYTE_DEFAULT.
REQ-028 The inter-byte timeout SHALL be the sub-module byte_timer (ports: clk, rst, clear, enable, expired).
REQ-029 The FSM, checksum, address counter and port mux SHALL be in prog_loader.

Verification
REQ-030 Good load:
   - stimulus: load_req, then 4C 00 02 34 12 CD AB BE.
   - required: writes 0300h<=1234h and 0302h<=ABCDh, each one cycle wide; then RUN; cpu_rst falls one cycle later; err=0.
REQ-031 Bad checksum: same frame ending in BF -> no RUN, err=1, cpu_rst=1; resending the good frame -> RUN, err=0.
REQ-032 Length bounds: N=0000h -> ERR; N=0681h -> ERR; N=0680h with a correct checksum -> last write at 0FFEh, then RUN.
REQ-033 Timeout: stall TIMEOUT_CYCLES after LEN_H -> ERR exactly at expiry; a byte on the expiry cycle -> no ERR.
REQ-034 Passthrough and load_req handling:
   - in RUN, random cpu_* -> mem_* identical every cycle.
   - load_req during DATA_L -> ignored.
REQ-035 Reset mid-load: assert rst after word 0 -> RUN with no further writes; cpu_rst released one cycle after rst falls.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_WAIT_HDR = 3'd1,
        ST_LEN_H    = 3'd2,
        ST_LEN_L    = 3'd3,
        ST_DATA_L   = 3'd4,
        ST_DATA_H   = 3'd5,
        ST_CSUM     = 3'd6,
        ST_ERR      = 3'd7
    } state_e;

    localparam logic [11:0] PROG_BASE        = 12'h300;
    localparam logic [10:0] PROG_MAX_WORDS   = 11'h680;
    localparam logic [7:0]  HDR_BYTE_DEFAULT = 8'h4C;

    // Running 8-bit wrap-around checksum over data bytes.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/prog_loader_byte_timer.sv
// Inter-byte idle counter: expired flags the TIMEOUT_CYCLES-th idle cycle since the last byte.
module byte_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 2_700_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: restart on a byte or when disabled, saturate at the last idle cycle.
    always_comb begin
        count_d = count_q;
        if (clear || !enable) begin
            count_d = '0;
        end else if (count_q != LAST) begin
            count_d = count_q + CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // A byte arriving on the expiry cycle takes precedence over the timeout.
    assign expired = enable && !clear && (count_q == LAST);

endmodule

// File: rtl/prog_loader.sv
// UART program loader: receives a framed program, writes it at PROG_BASE while
// holding the CPU in reset, and otherwise passes CPU memory traffic straight through.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 2_700_000,
    parameter logic [7:0]  HDR_BYTE       = HDR_BYTE_DEFAULT,
    parameter int          ADDR_WIDTH     = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_req,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic                  cpu_wr,
    input  logic                  cpu_byt,
    input  logic [15:0]           cpu_wr_data,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_wr,
    output logic                  mem_byt,
    output logic [15:0]           mem_wr_data,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  err
);

    state_e                state_q, state_d;
    logic [7:0]            len_hi_q, len_hi_d;
    logic [10:0]           len_q, len_d;
    logic [7:0]            lo_q, lo_d;
    logic [10:0]           idx_q, idx_d;
    logic [7:0]            csum_q, csum_d;
    logic                  wr_pend_q, wr_pend_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]           wr_data_q, wr_data_d;
    logic                  cpu_rst_q, cpu_rst_d;
    logic                  err_q, err_d;

    logic                  timed_s;
    logic                  expired_s;
    logic                  is_hdr_s;
    logic [15:0]           len16_s;

    assign timed_s  = (state_q == ST_LEN_H) || (state_q == ST_LEN_L) || (state_q == ST_DATA_L)
                   || (state_q == ST_DATA_H) || (state_q == ST_CSUM);
    assign is_hdr_s = rx_valid && (rx_data == HDR_BYTE);
    assign len16_s  = {len_hi_q, rx_data};

    byte_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (rx_valid),
        .enable  (timed_s),
        .expired (expired_s)
    );

    // Next-state logic; states only advance on rx_valid, so the timeout default is overridden by a byte.
    always_comb begin
        state_d   = expired_s ? ST_ERR : state_q;
        len_hi_d  = len_hi_q;
        len_d     = len_q;
        lo_d      = lo_q;
        idx_d     = idx_q;
        csum_d    = csum_q;
        wr_pend_d = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            ST_RUN: begin
                if (load_req) begin
                    state_d = ST_WAIT_HDR;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_WAIT_HDR, ST_ERR: begin
                if ((state_q == ST_ERR) && load_req) begin
                    state_d = ST_WAIT_HDR;
                end else if (is_hdr_s) begin
                    state_d = ST_LEN_H;
                    idx_d   = 11'd0;
                    csum_d  = 8'd0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LEN_H: begin
                if (rx_valid) begin
                    len_hi_d = rx_data;
                    state_d  = ST_LEN_L;
                end else begin
                    len_hi_d = len_hi_q;
                end
            end
            ST_LEN_L: begin
                if (rx_valid) begin
                    if ((len16_s == 16'h0000) || (len16_s > {5'd0, PROG_MAX_WORDS})) begin
                        state_d = ST_ERR;
                    end else begin
                        len_d   = len16_s[10:0];
                        state_d = ST_DATA_L;
                    end
                end else begin
                    len_d = len_q;
                end
            end
            ST_DATA_L: begin
                if (rx_valid) begin
                    lo_d    = rx_data;
                    csum_d  = csum_add(csum_q, rx_data);
                    state_d = ST_DATA_H;
                end else begin
                    lo_d = lo_q;
                end
            end
            ST_DATA_H: begin
                if (rx_valid) begin
                    wr_pend_d = 1'b1;
                    wr_addr_d = ADDR_WIDTH'(PROG_BASE + {idx_q, 1'b0});
                    wr_data_d = {rx_data, lo_q};
                    csum_d    = csum_add(csum_q, rx_data);
                    idx_d     = idx_q + 11'd1;
                    state_d   = (idx_q == (len_q - 11'd1)) ? ST_CSUM : ST_DATA_L;
                end else begin
                    wr_pend_d = 1'b0;
                end
            end
            ST_CSUM: begin
                if (rx_valid) begin
                    state_d = (rx_data == csum_q) ? ST_RUN : ST_ERR;
                end else begin
                    csum_d = csum_q;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        // The CPU leaves reset only once the FSM has already settled in RUN for a cycle.
        cpu_rst_d = (state_d != ST_RUN) || (state_q != ST_RUN);
        err_d     = (state_d == ST_ERR);
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RUN;
            len_hi_q  <= 8'd0;
            len_q     <= 11'd0;
            lo_q      <= 8'd0;
            idx_q     <= 11'd0;
            csum_q    <= 8'd0;
            wr_pend_q <= 1'b0;
            wr_addr_q <= ADDR_WIDTH'(PROG_BASE);
            wr_data_q <= 16'h0000;
            cpu_rst_q <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_hi_q  <= len_hi_d;
            len_q     <= len_d;
            lo_q      <= lo_d;
            idx_q     <= idx_d;
            csum_q    <= csum_d;
            wr_pend_q <= wr_pend_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            cpu_rst_q <= cpu_rst_d;
            err_q     <= err_d;
        end
    end

    // Memory port mux: CPU passthrough in RUN, loader-owned otherwise.
    always_comb begin
        mem_addr    = ADDR_WIDTH'(PROG_BASE);
        mem_wr      = 1'b0;
        mem_byt     = 1'b0;
        mem_wr_data = 16'h0000;
        if (state_q == ST_RUN) begin
            mem_addr    = cpu_addr;
            mem_wr      = cpu_wr;
            mem_byt     = cpu_byt;
            mem_wr_data = cpu_wr_data;
        end else if (wr_pend_q) begin
            mem_addr    = wr_addr_q;
            mem_wr      = 1'b1;
            mem_wr_data = wr_data_q;
        end else begin
            mem_addr    = ADDR_WIDTH'(PROG_BASE);
            mem_wr      = 1'b0;
        end
    end

    assign cpu_rst = cpu_rst_q;
    assign err     = err_q;
    assign busy    = (state_q != ST_RUN);

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected writes, a negedge monitor pops and compares.
module tb_prog_loader;

    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_req;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [11:0] cpu_addr;
    logic        cpu_wr;
    logic        cpu_byt;
    logic [15:0] cpu_wr_data;
    logic [11:0] mem_addr;
    logic        mem_wr;
    logic        mem_byt;
    logic [15:0] mem_wr_data;
    logic        cpu_rst;
    logic        busy;
    logic        err;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [27:0] sb_q[$];
    logic [27:0] exp_w;
    logic [11:0] last_wr_addr;
    logic        mon_en;
    logic        prev_rxv;
    logic [7:0]  cs;
    logic [15:0] w;
    logic [29:0] pt;

    prog_loader #(.TIMEOUT_CYCLES(TO), .HDR_BYTE(8'h4C), .ADDR_WIDTH(12)) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .rx_data(rx_data), .rx_valid(rx_valid),
        .cpu_addr(cpu_addr), .cpu_wr(cpu_wr), .cpu_byt(cpu_byt), .cpu_wr_data(cpu_wr_data),
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_byt(mem_byt), .mem_wr_data(mem_wr_data),
        .cpu_rst(cpu_rst), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) prev_rxv <= rx_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Write monitor: every loader write must match the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && (mem_wr === 1'b1)) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got %0h<=%0h, required no write", mem_addr, mem_wr_data);
                end else begin
                    exp_w = sb_q.pop_front();
                    last_wr_addr = mem_addr;
                    check("wr_addr", 32'(mem_addr), 32'(exp_w[27:16]));
                    check("wr_data", 32'(mem_wr_data), 32'(exp_w[15:0]));
                    check("wr_byt", 32'(mem_byt), 32'h0);
                    check("wr_after_byte", 32'(prev_rxv), 32'h1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        send_byte(b);
        tick();
    endtask

    task automatic pulse_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic push_good();
        sb_q.push_back({12'h300, 16'h1234});
        sb_q.push_back({12'h302, 16'hABCD});
    endtask

    // 4C 00 02 34 12 CD AB <last>, one idle cycle between bytes.
    task automatic send_frame(input logic [7:0] last);
        send_gap(8'h4C); send_gap(8'h00); send_gap(8'h02); send_gap(8'h34);
        send_gap(8'h12); send_gap(8'hCD); send_gap(8'hAB); send_byte(last);
    endtask

    initial begin
        rst = 1'b1; load_req = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        cpu_addr = 12'h123; cpu_wr = 1'b0; cpu_byt = 1'b1; cpu_wr_data = 16'hBEEF; mon_en = 1'b1;
        repeat (3) tick();
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_cpu_rst", 32'(cpu_rst), 32'h1);
        check("rst_err", 32'(err), 32'h0);
        check("rst_mux_addr", 32'(mem_addr), 32'h123);
        check("rst_mux_byt", 32'(mem_byt), 32'h1);
        rst = 1'b0;
        check("rst_hold_cpu_rst", 32'(cpu_rst), 32'h1);
        tick();
        check("rst_release", 32'(cpu_rst), 32'h0);
        cpu_addr = 12'h000; cpu_byt = 1'b0; cpu_wr_data = 16'h0000;

        // Good load with explicit write-pulse timing.
        pulse_load();
        check("ld_cpu_rst", 32'(cpu_rst), 32'h1);
        check("ld_busy", 32'(busy), 32'h1);
        check("ld_idle_addr", 32'(mem_addr), 32'h300);
        check("ld_idle_wr", 32'(mem_wr), 32'h0);
        push_good();
        send_gap(8'h4C); send_gap(8'h00); send_gap(8'h02); send_gap(8'h34);
        send_byte(8'h12);
        check("good_wr0_pulse", 32'(mem_wr), 32'h1);
        tick();
        check("good_wr0_end", 32'(mem_wr), 32'h0);
        send_gap(8'hCD); send_gap(8'hAB); send_byte(8'hBE);
        check("good_run", 32'(busy), 32'h0);
        check("good_cpu_rst_hold", 32'(cpu_rst), 32'h1);
        check("good_err", 32'(err), 32'h0);
        tick();
        check("good_cpu_rst_fall", 32'(cpu_rst), 32'h0);
        check("good_drain", 32'(sb_q.size()), 32'h0);

        // Bad checksum, then recovery from ERR by resending.
        pulse_load();
        push_good();
        send_frame(8'hBF);
        tick();
        check("badcs_busy", 32'(busy), 32'h1);
        check("badcs_err", 32'(err), 32'h1);
        check("badcs_cpu_rst", 32'(cpu_rst), 32'h1);
        push_good();
        send_frame(8'hBE);
        check("resend_run", 32'(busy), 32'h0);
        check("resend_err", 32'(err), 32'h0);
        tick();
        check("resend_cpu_rst", 32'(cpu_rst), 32'h0);
        check("badcs_drain", 32'(sb_q.size()), 32'h0);

        // Length bounds.
        pulse_load();
        send_gap(8'h4C); send_gap(8'h00); send_byte(8'h00);
        check("len0_err", 32'(err), 32'h1);
        send_byte(8'h4C);
        check("hdr_clears_err", 32'(err), 32'h0);
        send_gap(8'h06); send_byte(8'h81);
        check("len681_err", 32'(err), 32'h1);
        send_gap(8'h4C); send_gap(8'h06); send_gap(8'h80);
        cs = 8'h00;
        for (int i = 0; i < 1664; i++) begin
            w = 16'(i * 7) ^ 16'hC35A;
            sb_q.push_back({12'(768 + 2 * i), w});
            cs = cs + w[7:0] + w[15:8];
            send_byte(w[7:0]);
            send_byte(w[15:8]);
        end
        send_gap(cs);
        check("len680_run", 32'(busy), 32'h0);
        check("len680_err", 32'(err), 32'h0);
        check("len680_last_addr", 32'(last_wr_addr), 32'hFFE);
        check("len680_drain", 32'(sb_q.size()), 32'h0);

        // Passthrough in RUN with random CPU traffic.
        mon_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            pt = 30'($urandom);
            cpu_addr = pt[29:18]; cpu_wr = pt[17]; cpu_byt = pt[16]; cpu_wr_data = pt[15:0];
            #1;
            check("passthru", 32'({mem_addr, mem_wr, mem_byt, mem_wr_data}), 32'(pt));
            tick();
        end
        cpu_addr = 12'h000; cpu_wr = 1'b0; cpu_byt = 1'b0; cpu_wr_data = 16'h0000;
        tick();
        mon_en = 1'b1;

        // load_req while in DATA_L must be ignored.
        pulse_load();
        push_good();
        send_gap(8'h4C); send_gap(8'h00); send_gap(8'h02);
        pulse_load();
        check("ldreq_datal_busy", 32'(busy), 32'h1);
        send_gap(8'h34); send_gap(8'h12); send_gap(8'hCD); send_gap(8'hAB); send_byte(8'hBE);
        check("ldreq_datal_run", 32'(busy), 32'h0);
        tick();
        check("ldreq_datal_drain", 32'(sb_q.size()), 32'h0);

        // Timeout fires exactly TO idle cycles after the header.
        pulse_load();
        send_byte(8'h4C);
        repeat (TO - 1) tick();
        check("to_before", 32'(err), 32'h0);
        tick();
        check("to_expiry", 32'(err), 32'h1);
        pulse_load();
        check("to_ldreq_clear", 32'(err), 32'h0);
        send_byte(8'h4C);
        repeat (TO - 1) tick();
        send_byte(8'h00);
        check("to_byte_wins", 32'(err), 32'h0);
        sb_q.push_back({12'h300, 16'h2211});
        send_gap(8'h01); send_gap(8'h11); send_gap(8'h22); send_byte(8'h33);
        check("to_frame_run", 32'(busy), 32'h0);
        check("to_frame_err", 32'(err), 32'h0);
        tick();

        // Reset mid-load after word 0.
        pulse_load();
        sb_q.push_back({12'h300, 16'h1234});
        send_gap(8'h4C); send_gap(8'h00); send_gap(8'h02); send_gap(8'h34); send_gap(8'h12);
        rst = 1'b1;
        tick();
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_cpu_rst", 32'(cpu_rst), 32'h1);
        check("midrst_err", 32'(err), 32'h0);
        tick();
        rst = 1'b0;
        check("midrst_hold", 32'(cpu_rst), 32'h1);
        send_byte(8'hCD);
        check("midrst_release", 32'(cpu_rst), 32'h0);
        tick(); send_gap(8'hAB); send_gap(8'hBE);
        check("midrst_run", 32'(busy), 32'h0);
        check("midrst_drain", 32'(sb_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
